// File: rtl/aux_write_arbiter_pkg.sv
// Shared types and widths for the AUX write arbiter slice.
package aux_write_arbiter_pkg;

   localparam int unsigned AUX_ADDR_W = 24;
   localparam int unsigned AUX_DATA_W = 32;

   typedef enum logic {
      MASTER_CPU    = 1'b0,
      MASTER_COPPER = 1'b1
   } aux_master_e;

endpackage : aux_write_arbiter_pkg

// File: rtl/aux_write_arbiter_fifo.sv
// Synchronous FIFO with push/pop/full/empty/count; data storage is not reset.
module aux_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 56
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head is forced to zero when nothing is queued so the bus never shows stale data.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule : aux_fifo

// File: rtl/aux_write_arbiter.sv
// Round-robin arbiter between copper and CPU AUX write masters, buffered by a small FIFO.
module aux_write_arbiter
   import aux_write_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = AUX_ADDR_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  copper_aux_request,
   output logic                  copper_aux_ack,
   input  logic [ADDR_W-1:0]     copper_aux_address,
   input  logic [AUX_DATA_W-1:0] copper_aux_wdata,
   input  logic                  cpu_aux_request,
   output logic                  cpu_aux_ack,
   input  logic [ADDR_W-1:0]     cpu_aux_address,
   input  logic [AUX_DATA_W-1:0] cpu_aux_wdata,
   output logic                  aux_valid,
   input  logic                  aux_ready,
   output logic [ADDR_W-1:0]     aux_address,
   output logic [AUX_DATA_W-1:0] aux_wdata,
   output logic                  aux_idle
);

   localparam int unsigned WIDTH = ADDR_W + AUX_DATA_W;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   aux_master_e      last_grant;
   logic             grant_copper_c;
   logic             grant_cpu_c;
   logic             push_c;
   logic [WIDTH-1:0] push_data_c;
   logic [WIDTH-1:0] head_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   // Grant decision; a same-cycle pop never frees a slot, so only full gates acceptance.
   always_comb begin
      grant_copper_c = 1'b0;
      grant_cpu_c    = 1'b0;
      if (!fifo_full) begin
         if (copper_aux_request && cpu_aux_request) begin
            grant_copper_c = (last_grant == MASTER_CPU);
            grant_cpu_c    = (last_grant == MASTER_COPPER);
         end else begin
            grant_copper_c = copper_aux_request;
            grant_cpu_c    = cpu_aux_request;
         end
      end
   end

   assign push_c      = grant_copper_c | grant_cpu_c;
   assign push_data_c = grant_copper_c ? {copper_aux_address, copper_aux_wdata}
                                       : {cpu_aux_address, cpu_aux_wdata};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant <= MASTER_CPU;
      end else if (grant_copper_c) begin
         last_grant <= MASTER_COPPER;
      end else if (grant_cpu_c) begin
         last_grant <= MASTER_CPU;
      end
   end

   aux_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_c),
      .push_data (push_data_c),
      .pop       (aux_ready),
      .pop_data  (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign copper_aux_ack = grant_copper_c;
   assign cpu_aux_ack    = grant_cpu_c;
   assign aux_valid      = !fifo_empty;
   assign aux_address    = head_data[WIDTH-1 -: ADDR_W];
   assign aux_wdata      = head_data[AUX_DATA_W-1:0];
   assign aux_idle       = (fifo_count == '0) && !copper_aux_request && !cpu_aux_request;

endmodule : aux_write_arbiter

// File: tb/tb_aux_write_arbiter.sv
// Randomised bench for aux_write_arbiter against a queue-based model of the arbitration rules.
module tb_aux_write_arbiter;

   localparam int unsigned DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        c_req = 1'b0;
   logic [23:0] c_addr = '0;
   logic [31:0] c_wdata = '0;
   logic        p_req = 1'b0;
   logic [23:0] p_addr = '0;
   logic [31:0] p_wdata = '0;
   logic        aux_ready = 1'b0;
   logic        copper_aux_ack;
   logic        cpu_aux_ack;
   logic        aux_valid;
   logic [23:0] aux_address;
   logic [31:0] aux_wdata;
   logic        aux_idle;

   int checks   = 0;
   int failures = 0;

   logic [55:0] model_q [$];
   bit          last_copper = 1'b0;

   aux_write_arbiter #(.DEPTH(DEPTH)) dut (
      .clock              (clock),
      .reset              (reset),
      .copper_aux_request (c_req),
      .copper_aux_ack     (copper_aux_ack),
      .copper_aux_address (c_addr),
      .copper_aux_wdata   (c_wdata),
      .cpu_aux_request    (p_req),
      .cpu_aux_ack        (cpu_aux_ack),
      .cpu_aux_address    (p_addr),
      .cpu_aux_wdata      (p_wdata),
      .aux_valid          (aux_valid),
      .aux_ready          (aux_ready),
      .aux_address        (aux_address),
      .aux_wdata          (aux_wdata),
      .aux_idle           (aux_idle)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock per iteration: check at negedge, update model at posedge, then drive new inputs.
   task automatic run_cycles(input int n, input int c_pct, input int p_pct, input int rdy_pct);
      for (int i = 0; i < n; i++) begin
         bit          full;
         bit          exp_c;
         bit          exp_p;
         bit          exp_pop;
         logic [55:0] head;
         aux_ready = ($urandom_range(99) < rdy_pct);
         @(negedge clock);
         full  = (model_q.size() >= DEPTH);
         exp_c = 1'b0;
         exp_p = 1'b0;
         if (!full) begin
            if (c_req && p_req) begin
               exp_c = !last_copper;
               exp_p = last_copper;
            end else begin
               exp_c = c_req;
               exp_p = p_req;
            end
         end
         check_eq("copper_ack", 64'(copper_aux_ack), 64'(exp_c));
         check_eq("cpu_ack", 64'(cpu_aux_ack), 64'(exp_p));
         check_eq("aux_valid", 64'(aux_valid), 64'(model_q.size() != 0));
         check_eq("aux_idle", 64'(aux_idle), 64'((model_q.size() == 0) && !c_req && !p_req));
         if (model_q.size() != 0) begin
            head = model_q[0];
            check_eq("aux_address", 64'(aux_address), 64'(head[55:32]));
            check_eq("aux_wdata", 64'(aux_wdata), 64'(head[31:0]));
         end
         exp_pop = (model_q.size() != 0) && aux_ready;
         @(posedge clock);
         if (exp_pop) void'(model_q.pop_front());
         if (exp_c) begin
            model_q.push_back({c_addr, c_wdata});
            last_copper = 1'b1;
         end
         if (exp_p) begin
            model_q.push_back({p_addr, p_wdata});
            last_copper = 1'b0;
         end
         #1;
         if (exp_c || !c_req) begin
            c_req   = ($urandom_range(99) < c_pct);
            c_addr  = 24'($urandom);
            c_wdata = $urandom;
         end
         if (exp_p || !p_req) begin
            p_req   = ($urandom_range(99) < p_pct);
            p_addr  = 24'($urandom);
            p_wdata = $urandom;
         end
      end
   endtask

   initial begin
      // Reset state
      #12;
      check_eq("rst_valid", 64'(aux_valid), 64'(0));
      check_eq("rst_address", 64'(aux_address), 64'(0));
      check_eq("rst_wdata", 64'(aux_wdata), 64'(0));
      check_eq("rst_copper_ack", 64'(copper_aux_ack), 64'(0));
      check_eq("rst_cpu_ack", 64'(cpu_aux_ack), 64'(0));
      check_eq("rst_idle", 64'(aux_idle), 64'(1));
      @(posedge clock);
      #2 reset = 1'b0;

      // Single copper write with ready high
      c_req   = 1'b1;
      c_addr  = 24'h000010;
      c_wdata = 32'hDEADBEEF;
      run_cycles(3, 0, 0, 100);

      // Both masters continuous: strict alternation
      run_cycles(12, 100, 100, 100);
      run_cycles(6, 0, 0, 100);

      // Fill with target stalled, then release
      run_cycles(8, 100, 0, 0);
      run_cycles(8, 100, 0, 100);

      // Steady push+pop: pointers wrap with one entry resident
      run_cycles(12, 100, 0, 100);

      // Random mix
      run_cycles(400, 50, 50, 60);
      run_cycles(200, 90, 90, 30);

      // Async reset with entries queued and a CPU request held across it
      run_cycles(8, 0, 0, 100);
      run_cycles(3, 100, 0, 0);
      check_eq("pre_rst_valid", 64'(aux_valid), 64'(1));
      c_req   = 1'b0;
      p_req   = 1'b1;
      p_addr  = 24'h0ABCDE;
      p_wdata = 32'h12345678;
      #2 reset = 1'b1;
      #1;
      check_eq("mid_rst_valid", 64'(aux_valid), 64'(0));
      model_q.delete();
      last_copper = 1'b0;
      @(posedge clock);
      #2 reset = 1'b0;
      run_cycles(2, 0, 0, 100);

      run_cycles(300, 60, 60, 50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_aux_write_arbiter

// File: doc/aux_write_arbiter.md
Name: aux_write_arbiter

Overview:
- Sits between the AUX-bus write masters (copper, CPU hwregs path) and the AUX register target bus.
- Arbitrates round-robin between the two masters and buffers accepted writes in a small FIFO.
- Presents buffered writes to the target with a valid/ready handshake.
- Lets the copper issue back-to-back MOVE writes without stalling on slow targets.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 24, AUX address width (implied 0xE0 prefix is outside this block).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- copper_aux_request  in  1  copper write request, held until acked
- copper_aux_ack  out  1  combinational accept for copper, same cycle
- copper_aux_address  in  24  copper write address
- copper_aux_wdata  in  32  copper write data
- cpu_aux_request  in  1  CPU write request, held until acked
- cpu_aux_ack  out  1  combinational accept for CPU, same cycle
- cpu_aux_address  in  24  CPU write address
- cpu_aux_wdata  in  32  CPU write data
- aux_valid  out  1  FIFO head holds a write
- aux_ready  in  1  target accepts head this cycle
- aux_address  out  24  head address
- aux_wdata  out  32  head data
- aux_idle  out  1  FIFO empty and no request pending

Behaviour:
- Reset (async, active-high):
  - count=0, rd/wr pointers=0, last_grant=CPU (so copper wins the first tie).
  - aux_valid=0, aux_address=0, aux_wdata=0, both acks=0, aux_idle=1 (when no request).
  - Any queued writes are discarded. A request held across reset is re-arbitrated after release.
- Accept condition: full = (count==DEPTH).
  - Acks are gated by full only. A same-cycle pop does NOT free a slot, so an accept never depends on aux_ready.
- Arbitration, combinational, when !full:
  - Only one master requesting: ack that master.
  - Both requesting: ack the master that is not last_grant.
  - At most one ack per cycle. The acked master's address/data are pushed that cycle.
  - last_grant updates to the acked master on each accept.
- Output:
  - aux_valid = (count!=0). aux_address/aux_wdata show the head entry.
  - Pop occurs when aux_valid && aux_ready.
- Latency: a write accepted in cycle N is visible on aux_valid in cycle N+1 at the earliest.
- Ordering: writes are presented in acceptance order, exactly once.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Legal only when !full, which follows from the accept rule.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Fairness: with both masters requesting continuously and no stalls, acks alternate every cycle.
- aux_ready while !aux_valid: ignored, no state change.
- aux_idle = (count==0) && !copper_aux_request && !cpu_aux_request.
- Storage: FIFO storage is plain registers (no reset needed on data). Pointer, count and last_grant registers use async reset.

Decomposition:
- Shared package: AUX_ADDR_W=24; a master-id enum {MASTER_CPU, MASTER_COPPER}.
- One sub-module: aux_fifo (parameterised DEPTH/width synchronous FIFO with push/pop/full/empty/count).
  - The top level holds the arbiter and last_grant register.

Test Plan:
- Reset, then copper writes addr 0x000010 data 0xDEADBEEF with aux_ready=1 -> copper_aux_ack same cycle; next cycle aux_valid=1, addr 0x000010, data 0xDEADBEEF; popped; aux_idle=1 after.
- Both masters request continuously (copper 0x100.., CPU 0x200..), aux_ready=1 -> acks alternate copper, CPU, copper, CPU; output order matches.
- aux_ready=0, copper requests 6 writes, DEPTH=4 -> first 4 acked, ack low with request held; raise aux_ready -> one pop per cycle; 5th write acked the cycle after the first pop, not the pop cycle.
- FIFO full, aux_ready=1 and copper requesting -> pop occurs, no ack that cycle; ack next cycle; count returns to 4.
- Push and pop for 10 consecutive cycles -> pointers wrap twice at DEPTH=4; data order intact; count stays 1.
- Assert reset asynchronously mid-clock with 3 entries queued -> aux_valid drops immediately; after release, queued writes are gone; a held CPU request is acked on the first cycle.
